pio_mem_arbiter: RTL and testbench

- Shares the single-outstanding PIO memory AXI4 slave between NUM_REQ requesters, e.g. the host PIO path and the RDMA engine.
- Round-robin arbitration with one transaction in flight at a time; the grant is locked from the address phase until the response completes.
- Sits between the requester AXI4 ports and the PIO memory slave's t_to_pio_axi4 / t_from_pio_axi4 pair.
- Holds address and data stable downstream for the whole transaction, because the slave samples araddr, awaddr and wdata after the handshake.

---
 rtl/ed_mc_axi_if_pkg.sv | 28 ++
 rtl/pio_arb_pkg.sv | 22 ++
 rtl/pio_rr_picker.sv | 37 +++
 rtl/pio_mem_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_pio_mem_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ed_mc_axi_if_pkg.sv
// ed_mc_axi_if_pkg: AXI4 bundle types for the PIO memory slave.
//   t_to_pio_axi4   : master -> PIO slave (AR/R-ready/AW/W/B-ready)
//   t_from_pio_axi4 : PIO slave -> master (ready flags, R data, B valid)
package ed_mc_axi_if_pkg;

  localparam int unsigned PIO_ADDR_W = 64;
  localparam int unsigned PIO_DATA_W = 1024;

  typedef struct packed {
    logic                  arvalid;
    logic [PIO_ADDR_W-1:0] araddr;
    logic                  rready;
    logic                  awvalid;
    logic [PIO_ADDR_W-1:0] awaddr;
    logic                  wvalid;
    logic [PIO_DATA_W-1:0] wdata;
    logic                  bready;
  } t_to_pio_axi4;

  typedef struct packed {
    logic                  arready;
    logic                  rvalid;
    logic [PIO_DATA_W-1:0] rdata;
    logic                  awready;
    logic                  bvalid;
  } t_from_pio_axi4;

endpackage

// File: rtl/pio_arb_pkg.sv
// pio_arb_pkg: shared types for the PIO memory arbiter family.
//   t_arb_state : arbiter FSM states
//   t_txn_kind  : kind of the granted transaction
//   MAX_REQ     : largest supported requester count
package pio_arb_pkg;

  localparam int unsigned MAX_REQ = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_RESP
  } t_arb_state;

  typedef enum logic {
    TXN_RD,
    TXN_WR
  } t_txn_kind;

endpackage

// File: rtl/pio_rr_picker.sv
// pio_rr_picker: combinational round-robin first-one search.
//   req    : request vector
//   rr_ptr : highest-priority index (must be < NUM_REQ)
//   valid  : at least one request present
//   idx    : first requesting index at or after rr_ptr, with wrap
module pio_rr_picker
  import pio_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [PTR_W-1:0]   idx
);

  logic [PTR_W:0] sum;
  logic [PTR_W:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // rr_ptr + i stays below 2*NUM_REQ, so one conditional subtract wraps it
      sum  = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
      cand = (sum >= (PTR_W + 1)'(NUM_REQ)) ? sum - (PTR_W + 1)'(NUM_REQ) : sum;
      if (!valid && req[cand[PTR_W-1:0]]) begin
        valid = 1'b1;
        idx   = cand[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pio_mem_arbiter.sv
// pio_mem_arbiter: round-robin sharing of the single-outstanding PIO memory
// AXI4 slave between NUM_REQ requesters. One transaction in flight; the
// grant is locked from the address phase until the R/B response completes.
// Address and write data are held stable downstream after the handshake.
//   axi4_mm_clk / axi4_mm_rst_n : clock, async active-low reset
//   s_ar* / s_r*                : per-requester read channels (rdata broadcast)
//   s_aw* / s_w* / s_b*         : per-requester write channels
//   to_pio_axi4 / from_pio_axi4 : PIO memory slave bundle
// Optional: `define PIO_ARB_STATS_EN adds grant_cnt, one 32-bit wrapping
// completed-transaction counter per requester.
module pio_mem_arbiter
  import ed_mc_axi_if_pkg::*;
  import pio_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 1024
) (
  input  logic                  axi4_mm_clk,
  input  logic                  axi4_mm_rst_n,
  input  logic [NUM_REQ-1:0]    s_arvalid,
  input  logic [NUM_REQ*ADDR_W-1:0] s_araddr,
  output logic [NUM_REQ-1:0]    s_arready,
  output logic [NUM_REQ-1:0]    s_rvalid,
  output logic [DATA_W-1:0]     s_rdata,
  input  logic [NUM_REQ-1:0]    s_rready,
  input  logic [NUM_REQ-1:0]    s_awvalid,
  input  logic [NUM_REQ*ADDR_W-1:0] s_awaddr,
  input  logic [NUM_REQ-1:0]    s_wvalid,
  input  logic [NUM_REQ*DATA_W-1:0] s_wdata,
  output logic [NUM_REQ-1:0]    s_awready,
  output logic [NUM_REQ-1:0]    s_wready,
  output logic [NUM_REQ-1:0]    s_bvalid,
  input  logic [NUM_REQ-1:0]    s_bready,
  output t_to_pio_axi4          to_pio_axi4,
  input  t_from_pio_axi4        from_pio_axi4
`ifdef PIO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0] grant_cnt
`endif
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  t_arb_state          state, state_nxt;
  t_txn_kind           win_kind;
  logic [PTR_W-1:0]    rr_ptr, gnt_id;
  logic [ADDR_W-1:0]   hold_addr;
  logic [DATA_W-1:0]   hold_data;
  logic [NUM_REQ-1:0]  req;
  logic                pick_valid;
  logic [PTR_W-1:0]    pick_idx;
  logic                ar_hs, aw_hs, done;

  // Granted requester's inputs
  logic                g_arvalid, g_rready, g_awvalid, g_wvalid, g_bready;
  logic [ADDR_W-1:0]   g_araddr, g_awaddr;
  logic [DATA_W-1:0]   g_wdata;

  // A lone awvalid without wvalid does not count as a request
  assign req = s_arvalid | (s_awvalid & s_wvalid);

  pio_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  // Read wins when the winner presents both a read and a write
  assign win_kind = s_arvalid[pick_idx] ? TXN_RD : TXN_WR;

  always_comb begin
    g_arvalid = 1'b0;
    g_rready  = 1'b0;
    g_awvalid = 1'b0;
    g_wvalid  = 1'b0;
    g_bready  = 1'b0;
    g_araddr  = '0;
    g_awaddr  = '0;
    g_wdata   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == PTR_W'(i)) begin
        g_arvalid = s_arvalid[i];
        g_rready  = s_rready[i];
        g_awvalid = s_awvalid[i];
        g_wvalid  = s_wvalid[i];
        g_bready  = s_bready[i];
        g_araddr  = s_araddr[i*ADDR_W +: ADDR_W];
        g_awaddr  = s_awaddr[i*ADDR_W +: ADDR_W];
        g_wdata   = s_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ar_hs       = 1'b0;
    aw_hs       = 1'b0;
    done        = 1'b0;
    s_arready   = '0;
    s_rvalid    = '0;
    s_rdata     = '0;
    s_awready   = '0;
    s_wready    = '0;
    s_bvalid    = '0;
    to_pio_axi4 = '0;
    // Held copies keep addr/data stable once the slave has taken them
    to_pio_axi4.araddr = hold_addr;
    to_pio_axi4.awaddr = hold_addr;
    to_pio_axi4.wdata  = hold_data;

    unique case (state)
      IDLE: begin
        if (pick_valid) state_nxt = (win_kind == TXN_RD) ? RD_ADDR : WR_ADDR;
      end
      RD_ADDR: begin
        to_pio_axi4.arvalid = g_arvalid;
        to_pio_axi4.araddr  = g_araddr;
        s_arready[gnt_id]   = from_pio_axi4.arready;
        if (!g_arvalid) begin
          state_nxt = IDLE;
        end else if (from_pio_axi4.arready) begin
          ar_hs     = 1'b1;
          state_nxt = RD_DATA;
        end
      end
      RD_DATA: begin
        s_rvalid[gnt_id]   = from_pio_axi4.rvalid;
        s_rdata            = from_pio_axi4.rdata;
        to_pio_axi4.rready = g_rready;
        if (from_pio_axi4.rvalid && g_rready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      WR_ADDR: begin
        to_pio_axi4.awvalid = g_awvalid;
        to_pio_axi4.wvalid  = g_wvalid;
        to_pio_axi4.awaddr  = g_awaddr;
        to_pio_axi4.wdata   = g_wdata;
        s_awready[gnt_id]   = from_pio_axi4.awready;
        s_wready[gnt_id]    = from_pio_axi4.awready;
        if (!(g_awvalid && g_wvalid)) begin
          state_nxt = IDLE;
        end else if (from_pio_axi4.awready) begin
          aw_hs     = 1'b1;
          state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        s_bvalid[gnt_id]   = from_pio_axi4.bvalid;
        to_pio_axi4.bready = g_bready;
        if (from_pio_axi4.bvalid && g_bready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_id    <= '0;
      hold_addr <= '0;
      hold_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_valid) gnt_id <= pick_idx;
      if (ar_hs) hold_addr <= g_araddr;
      if (aw_hs) begin
        hold_addr <= g_awaddr;
        hold_data <= g_wdata;
      end
      // Aborted address phases leave rr_ptr untouched
      if (done) rr_ptr <= (gnt_id == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_id + PTR_W'(1);
    end
  end

`ifdef PIO_ARB_STATS_EN
  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n) begin
      grant_cnt <= '0;
    end else if (done) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (gnt_id == PTR_W'(i)) grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pio_mem_arbiter.sv
// tb_pio_mem_arbiter: scoreboard bench for pio_mem_arbiter with a
// behavioural PIO slave that samples araddr/awaddr/wdata one cycle after
// the handshake. Build with PIO_ARB_STATS_EN defined to also check grant_cnt.
module tb_pio_mem_arbiter;
  import ed_mc_axi_if_pkg::*;
  import pio_arb_pkg::*;

  localparam int unsigned NREQ = 2;
  localparam int unsigned AW   = 64;
  localparam int unsigned DW   = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    arvalid, rready, awvalid, wvalid, bready;
  logic [NREQ*AW-1:0] araddr, awaddr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
  logic [DW-1:0]      s_rdata;
  t_to_pio_axi4       to_pio;
  t_from_pio_axi4     from_pio;
`ifdef PIO_ARB_STATS_EN
  logic [NREQ*32-1:0] grant_cnt;
`endif

  pio_mem_arbiter #(
    .NUM_REQ (NREQ),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .axi4_mm_clk   (clk),
    .axi4_mm_rst_n (rst_n),
    .s_arvalid     (arvalid),
    .s_araddr      (araddr),
    .s_arready     (s_arready),
    .s_rvalid      (s_rvalid),
    .s_rdata       (s_rdata),
    .s_rready      (rready),
    .s_awvalid     (awvalid),
    .s_awaddr      (awaddr),
    .s_wvalid      (wvalid),
    .s_wdata       (wdata),
    .s_awready     (s_awready),
    .s_wready      (s_wready),
    .s_bvalid      (s_bvalid),
    .s_bready      (bready),
    .to_pio_axi4   (to_pio),
    .from_pio_axi4 (from_pio)
`ifdef PIO_ARB_STATS_EN
    ,
    .grant_cnt     (grant_cnt)
`endif
  );

  // ---------------- PIO slave model ----------------
  logic [DW-1:0] smem [16];
  logic          rd_pend, wr_pend, srv, sbv;
  logic [DW-1:0] srdata;

  function automatic logic [DW-1:0] init_val(input int e);
    logic [31:0] w;
    w = 32'hC0DE_0000 | 32'(e);
    return {32{w}};
  endfunction

  always_comb begin
    from_pio         = '0;
    from_pio.arready = !(rd_pend || wr_pend || srv || sbv);
    from_pio.awready = !(rd_pend || wr_pend || srv || sbv);
    from_pio.rvalid  = srv;
    from_pio.rdata   = srdata;
    from_pio.bvalid  = sbv;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
      wr_pend <= 1'b0;
      srv     <= 1'b0;
      sbv     <= 1'b0;
      srdata  <= '0;
    end else begin
      if (to_pio.arvalid && from_pio.arready) rd_pend <= 1'b1;
      if (to_pio.awvalid && to_pio.wvalid && from_pio.awready) wr_pend <= 1'b1;
      if (rd_pend) begin
        srdata  <= smem[to_pio.araddr[11:8]];
        srv     <= 1'b1;
        rd_pend <= 1'b0;
      end
      if (wr_pend) begin
        sbv     <= 1'b1;
        wr_pend <= 1'b0;
      end
      if (srv && to_pio.rready) srv <= 1'b0;
      if (sbv && to_pio.bready) sbv <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int e = 0; e < 16; e++) smem[e] <= init_val(e);
    end else if (wr_pend) begin
      smem[to_pio.awaddr[11:8]] <= to_pio.wdata;
    end
  end

  // ---------------- checking / scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int            id;
    bit            wr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] shadow [16];
  int            cmpl_cnt [NREQ];
  int            exp_rr;
  bit            seen_ar1;

  function automatic exp_t mk(input int id, input bit wr, input logic [DW-1:0] d);
    exp_t e;
    e.id = id; e.wr = wr; e.data = d;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (s_arready[1]) seen_ar1 = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (s_rvalid[i] && rready[i]) begin
          if (sb.size() == 0) begin
            check_eq("rd_unexpected", DW'(sb.size()), DW'(1));
          end else begin
            e = sb.pop_front();
            check_eq("rd_id", DW'(i), DW'(e.id));
            check_eq("rd_kind", DW'(0), DW'(e.wr));
            check_eq("rdata", s_rdata, e.data);
          end
          cmpl_cnt[i]++;
          exp_rr = (i + 1) % NREQ;
        end
        if (s_bvalid[i] && bready[i]) begin
          if (sb.size() == 0) begin
            check_eq("wr_unexpected", DW'(sb.size()), DW'(1));
          end else begin
            e = sb.pop_front();
            check_eq("wr_id", DW'(i), DW'(e.id));
            check_eq("wr_kind", DW'(1), DW'(e.wr));
          end
          cmpl_cnt[i]++;
          exp_rr = (i + 1) % NREQ;
        end
      end
    end
  end

  // ---------------- requester tasks (drive at posedge+1, sample at negedge) ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_req(input int id, input logic [AW-1:0] a);
    int n = 0;
    bit r = 1'b0;
    araddr[id*AW +: AW] = a;
    arvalid[id] = 1'b1;
    do begin
      @(negedge clk);
      r = s_arready[id];
      step();
      n++;
    end while (!r && n < 400);
    if (!r) check_eq("ar_timeout", DW'(r), DW'(1));
    arvalid[id] = 1'b0;
  endtask

  task automatic wr_req(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    bit r = 1'b0;
    awaddr[id*AW +: AW] = a;
    wdata[id*DW +: DW] = d;
    awvalid[id] = 1'b1;
    wvalid[id]  = 1'b1;
    do begin
      @(negedge clk);
      r = s_awready[id];
      if (r) check_eq("wready_with_awready", DW'(s_wready[id]), DW'(1));
      step();
      n++;
    end while (!r && n < 400);
    if (!r) check_eq("aw_timeout", DW'(r), DW'(1));
    awvalid[id] = 1'b0;
    wvalid[id]  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      step();
      n++;
    end
    check_eq(tag, DW'(sb.size()), DW'(0));
    step();
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_ready_valid"}, DW'({s_arready, s_rvalid, s_awready, s_wready, s_bvalid}), DW'(0));
    check_eq({tag, "_rdata"}, s_rdata, '0);
    check_eq({tag, "_to_pio_vr"},
             DW'({to_pio.arvalid, to_pio.awvalid, to_pio.wvalid, to_pio.rready, to_pio.bready}), DW'(0));
    check_eq({tag, "_state"}, DW'(dut.state), DW'(IDLE));
    check_eq({tag, "_rr_ptr"}, DW'(dut.rr_ptr), DW'(0));
    check_eq({tag, "_gnt_id"}, DW'(dut.gnt_id), DW'(0));
  endtask

  task automatic bench_reset_model();
    sb.delete();
    for (int e = 0; e < 16; e++) shadow[e] = init_val(e);
    for (int i = 0; i < NREQ; i++) cmpl_cnt[i] = 0;
    exp_rr = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int c0, c1, id;
    logic [DW-1:0] d;

    arvalid = '0; awvalid = '0; wvalid = '0;
    araddr = '0; awaddr = '0; wdata = '0;
    rready = '1; bready = '1;
    seen_ar1 = 1'b0;
    bench_reset_model();

    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst_n = 1'b1;
    step();

    // Concurrent reads, rr_ptr=0: req0 first, then req1
    sb.push_back(mk(0, 0, shadow[1]));
    sb.push_back(mk(1, 0, shadow[2]));
    fork
      rd_req(0, 64'h100);
      rd_req(1, 64'h200);
    join
    wait_drain("concurrent_drain");
    check_eq("concurrent_rr_ptr", DW'(dut.rr_ptr), DW'(exp_rr));
    check_eq("concurrent_rr_zero", DW'(dut.rr_ptr), DW'(0));

    // Single read with one-cycle request-to-downstream latency
    seen_ar1 = 1'b0;
    sb.push_back(mk(0, 0, shadow[3]));
    araddr[0 +: AW] = 64'h300;
    arvalid[0] = 1'b1;
    @(negedge clk);
    check_eq("lat_idle_arvalid", DW'(to_pio.arvalid), DW'(0));
    step();
    @(negedge clk);
    check_eq("lat_arvalid", DW'(to_pio.arvalid), DW'(1));
    check_eq("lat_araddr", DW'(to_pio.araddr), DW'(64'h300));
    check_eq("lat_arready0", DW'(s_arready[0]), DW'(1));
    step();
    arvalid[0] = 1'b0;
    wait_drain("single_drain");
    check_eq("single_arready1_quiet", DW'(seen_ar1), DW'(0));

    // Write from req1, then read it back from req0
    d = DW'(16'hDEAD);
    shadow[5] = d;
    sb.push_back(mk(1, 1, '0));
    wr_req(1, 64'h500, d);
    wait_drain("write_drain");
    sb.push_back(mk(0, 0, shadow[5]));
    rd_req(0, 64'h500);
    wait_drain("readback_drain");

    // Backpressure: rready low for 20 cycles with req1 write pending
    rready[0] = 1'b0;
    sb.push_back(mk(0, 0, shadow[3]));
    rd_req(0, 64'h300);
    n = 0;
    while (s_rvalid[0] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("bp_rvalid_seen", DW'(s_rvalid[0]), DW'(1));
    step();
    d = {32{32'h1234_5678}};
    shadow[6] = d;
    sb.push_back(mk(1, 1, '0));
    fork
      wr_req(1, 64'h600, d);
      begin
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          check_eq("bp_state", DW'(dut.state), DW'(RD_DATA));
          check_eq("bp_araddr", DW'(to_pio.araddr), DW'(64'h300));
          check_eq("bp_awready1", DW'(s_awready[1]), DW'(0));
          step();
        end
        rready[0] = 1'b1;
      end
    join
    wait_drain("bp_drain");
    sb.push_back(mk(0, 0, shadow[6]));
    rd_req(0, 64'h600);
    wait_drain("bp_readback_drain");

    // Fairness: 100 back-to-back reads, strict alternation
    c0 = cmpl_cnt[0];
    c1 = cmpl_cnt[1];
    for (int k = 0; k < 100; k++) begin
      id = (exp_rr + k) % NREQ;
      sb.push_back(mk(id, 0, (id == 0) ? shadow[7] : shadow[8]));
    end
    fork
      for (int k = 0; k < 50; k++) rd_req(0, 64'h700);
      for (int k = 0; k < 50; k++) rd_req(1, 64'h800);
    join
    wait_drain("fair_drain");
    check_eq("fair_cnt0", DW'(cmpl_cnt[0] - c0), DW'(50));
    check_eq("fair_cnt1", DW'(cmpl_cnt[1] - c1), DW'(50));
`ifdef PIO_ARB_STATS_EN
    check_eq("grant_cnt0", DW'(grant_cnt[31:0]), DW'(cmpl_cnt[0]));
    check_eq("grant_cnt1", DW'(grant_cnt[63:32]), DW'(cmpl_cnt[1]));
`endif

    // Reset while the write response is stalled
    bready[1] = 1'b0;
    sb.push_back(mk(1, 1, '0));
    wr_req(1, 64'h900, {32{32'hFEED_BEEF}});
    n = 0;
    @(negedge clk);
    while (s_bvalid[1] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_wr_resp_state", DW'(dut.state), DW'(WR_RESP));
    rst_n = 1'b0;
    #1;
    check_quiet("midrst");
`ifdef PIO_ARB_STATS_EN
    check_eq("midrst_grant_cnt", DW'(grant_cnt), DW'(0));
`endif
    bench_reset_model();
    repeat (2) @(posedge clk);
    #1;
    bready[1] = 1'b1;
    rst_n = 1'b1;
    step();

    // Normal read after reset
    sb.push_back(mk(0, 0, shadow[3]));
    rd_req(0, 64'h300);
    wait_drain("postrst_drain");
    check_eq("postrst_rr_ptr", DW'(dut.rr_ptr), DW'(1));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
